fir_tap_sequencer: RTL and testbench

Controller that sits in front of a `fastfir` instance and sequences coefficient reloads. On request it streams one bank of NTAPS coefficients from an external synchronous coefficient memory onto the FIR tap-write port. It gates the sample stream during the reload and can optionally flush the filter with zeros so that no output mixes old and new taps. Between reloads it forwards samples to the FIR with one cycle of latency.

---
 rtl/fir_tap_sequencer_if.sv | 33 +++
 rtl/fir_tap_sequencer.sv | 150 +++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_sequencer_if.sv
// Bundle for the fir_tap_sequencer ports: reload request, coefficient memory, tap write and sample paths.
// slave is the sequencer side; master is the upstream/memory/FIR side.
interface fir_tap_sequencer_if #(
  parameter int LGNTAPS  = 7,
  parameter int TW       = 12,
  parameter int IW       = 12,
  parameter int LGNBANKS = 2
);
  localparam int AW = LGNBANKS + LGNTAPS;

  logic                i_load;
  logic [LGNBANKS-1:0] i_bank;
  logic [AW-1:0]       o_coef_addr;
  logic [TW-1:0]       i_coef_data;
  logic                o_tap_wr;
  logic [TW-1:0]       o_tap;
  logic                i_ce;
  logic [IW-1:0]       i_sample;
  logic                o_ce;
  logic [IW-1:0]       o_sample;
  logic                o_busy;
  logic                o_overrun;

  modport slave (
    input  i_load, i_bank, i_coef_data, i_ce, i_sample,
    output o_coef_addr, o_tap_wr, o_tap, o_ce, o_sample, o_busy, o_overrun
  );

  modport master (
    output i_load, i_bank, i_coef_data, i_ce, i_sample,
    input  o_coef_addr, o_tap_wr, o_tap, o_ce, o_sample, o_busy, o_overrun
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Streams one NTAPS coefficient bank into a FIR and forwards samples with 1-cycle latency; samples arriving while
// busy are dropped and flagged in o_overrun. FIR_FLUSH_EN adds NTAPS zero samples after every reload.
module fir_tap_sequencer #(
  parameter int NTAPS    = 128,
  parameter int LGNTAPS  = 7,
  parameter int TW       = 12,
  parameter int IW       = 12,
  parameter int LGNBANKS = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  fir_tap_sequencer_if.slave bus
);
  localparam int AW = LGNBANKS + LGNTAPS;
  localparam logic [LGNTAPS:0] NTAPS_C = (LGNTAPS + 1)'(NTAPS);
  localparam logic [LGNTAPS:0] CNT_ONE = (LGNTAPS + 1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [LGNBANKS-1:0] bank_q, bank_d;
  logic [LGNBANKS-1:0] pend_bank_q, pend_bank_d;
  logic                pend_q, pend_d;
  logic [LGNTAPS:0]    cnt_q, cnt_d;
  logic                rd_vld_q, rd_vld_d;
  logic                tap_wr_q, tap_wr_d;
  logic [TW-1:0]       tap_q, tap_d;
  logic                ce_q, ce_d;
  logic [IW-1:0]       sample_q, sample_d;
  logic                overrun_q, overrun_d;
  logic                load_done;
  logic                exit_now;
  logic [AW-1:0]       addr;

  // The counter's extra MSB marks "all addresses issued"; the low bits are the in-bank index.
  assign addr = {bank_q, cnt_q[LGNTAPS-1:0]};

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    pend_d      = pend_q;
    pend_bank_d = pend_bank_q;
    cnt_d       = cnt_q;
    rd_vld_d    = 1'b0;
    tap_wr_d    = rd_vld_q;
    tap_d       = bus.i_coef_data;
    ce_d        = 1'b0;
    sample_d    = '0;
    overrun_d   = overrun_q;
    exit_now    = 1'b0;
    load_done   = (cnt_q == NTAPS_C) && !rd_vld_q;

    if (state_q != IDLE) begin
      if (bus.i_ce) overrun_d = 1'b1;
      if (bus.i_load) begin
        pend_d      = 1'b1;
        pend_bank_d = bus.i_bank;
      end
    end

    case (state_q)
      IDLE: begin
        ce_d     = bus.i_ce;
        sample_d = bus.i_sample;
        if (bus.i_load) begin
          state_d   = LOAD;
          bank_d    = bus.i_bank;
          cnt_d     = '0;
          overrun_d = 1'b0;
        end
      end
      LOAD: begin
        if (!cnt_q[LGNTAPS]) begin
          rd_vld_d = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
`ifdef FIR_FLUSH_EN
        // First flush pulse leaves on the same edge as the final tap write is retired.
        if (load_done) begin
          state_d = FLUSH;
          cnt_d   = CNT_ONE;
          ce_d    = 1'b1;
        end
`else
        exit_now = load_done;
`endif
      end
`ifdef FIR_FLUSH_EN
      FLUSH: begin
        if (cnt_q != NTAPS_C) begin
          ce_d  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end else begin
          exit_now = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A queued (or same-cycle) request chains straight into the next LOAD with no idle cycle.
    if (exit_now) begin
      if (pend_q || bus.i_load) begin
        state_d   = LOAD;
        bank_d    = bus.i_load ? bus.i_bank : pend_bank_q;
        cnt_d     = '0;
        pend_d    = 1'b0;
        overrun_d = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      bank_q      <= '0;
      pend_bank_q <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      rd_vld_q    <= 1'b0;
      tap_wr_q    <= 1'b0;
      tap_q       <= '0;
      ce_q        <= 1'b0;
      sample_q    <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      pend_bank_q <= pend_bank_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      rd_vld_q    <= rd_vld_d;
      tap_wr_q    <= tap_wr_d;
      tap_q       <= tap_d;
      ce_q        <= ce_d;
      sample_q    <= sample_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.o_coef_addr = addr;
  assign bus.o_tap_wr    = tap_wr_q;
  assign bus.o_tap       = tap_q;
  assign bus.o_ce        = ce_q;
  assign bus.o_sample    = sample_q;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_overrun   = overrun_q;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer at NTAPS=16: passthrough vector table, then reload, overrun, pending and reset sequences.
// Tap values and forwarded samples go through scoreboard queues; strobes/addresses are checked cycle by cycle.
module tb_fir_tap_sequencer;
  localparam int N    = 16;
  localparam int LGN  = 4;
  localparam int TW   = 12;
  localparam int IW   = 12;
  localparam int LGB  = 2;
`ifdef FIR_FLUSH_EN
  localparam bit FL   = 1'b1;
  localparam int DONE = 2 * N + 2;
`else
  localparam bit FL   = 1'b0;
  localparam int DONE = N + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_tap_sequencer_if #(.LGNTAPS(LGN), .TW(TW), .IW(IW), .LGNBANKS(LGB)) bus ();

  fir_tap_sequencer #(.NTAPS(N), .LGNTAPS(LGN), .TW(TW), .IW(IW), .LGNBANKS(LGB)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

  // Synchronous coefficient memory whose word equals its address.
  always @(posedge clk) bus.i_coef_data <= TW'(bus.o_coef_addr);

  int n_cmp = 0;
  int n_err = 0;
  int tap_q[$];
  int sample_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push_load(input int b);
    for (int k = 0; k < N; k++) tap_q.push_back(b * N + k);
    if (FL) for (int k = 0; k < N; k++) sample_q.push_back(0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_tap_wr) begin
        if (tap_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tap_extra @%0t: got tap %0h, expected no write", $time, bus.o_tap);
        end else chk("tap_val", 32'(bus.o_tap), 32'(tap_q.pop_front()));
      end
      if (bus.o_ce) begin
        if (sample_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL ce_extra @%0t: got sample %0h, expected no o_ce", $time, bus.o_sample);
        end else chk("sample_val", 32'(bus.o_sample), 32'(sample_q.pop_front()));
      end
    end
  end

  function automatic bit wr_at(input int d);
    return (d >= 2) && (d <= N + 1);
  endfunction

  function automatic bit fl_at(input int d);
    return FL && (d >= N + 2) && (d <= 2 * N + 1);
  endfunction

  // Cycles c=1..last after a load accepted at E0; an optional chained load starts at E(s2).
  task automatic walk(input int last, input int s2, input int b1, input int b2,
                      input int ce_from, input int ce_to, input int ld_a, input int bank_a,
                      input int ld_b, input int bank_b, input int ovr_from);
    for (int c = 1; c <= last; c++) begin
      int d2;
      @(negedge clk);
      d2 = (s2 > 0) ? c - s2 : -1;
      chk("busy", 32'(bus.o_busy), 32'((s2 > 0) ? (c < s2 + DONE) : (c < DONE)));
      chk("tap_wr", 32'(bus.o_tap_wr), 32'(wr_at(c) || (d2 >= 0 && wr_at(d2))));
      chk("ce", 32'(bus.o_ce), 32'(fl_at(c) || (d2 >= 0 && fl_at(d2))));
      chk("overrun", 32'(bus.o_overrun), 32'(ovr_from >= 0 && c >= ovr_from));
      if ((s2 == 0 || c < s2) && c <= N - 1) chk("addr", 32'(bus.o_coef_addr), 32'(b1 * N + c));
      else if (d2 >= 0 && d2 <= N - 1) chk("addr2", 32'(bus.o_coef_addr), 32'(b2 * N + d2));
      bus.i_ce     = (c >= ce_from) && (c <= ce_to);
      bus.i_sample = IW'(c + 100);
      bus.i_load   = (c == ld_a) || (c == ld_b);
      if (c == ld_a) bus.i_bank = LGB'(bank_a);
      if (c == ld_b) bus.i_bank = LGB'(bank_b);
    end
  endtask

  typedef struct {
    logic          ce;
    logic          load;
    logic [LGB-1:0] bank;
    logic [IW-1:0] sample;
    logic          exp_ce;
    logic          exp_busy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'd0, 12'h001, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 2'd0, 12'h002, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 2'd0, 12'h003, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 2'd0, 12'h009, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 2'd0, 12'hFFF, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 2'd2, 12'h005, 1'b1, 1'b1};

    bus.i_load = 1'b0; bus.i_bank = '0; bus.i_ce = 1'b0; bus.i_sample = '0;

    @(negedge clk);
    chk("rst_addr", 32'(bus.o_coef_addr), 0);
    chk("rst_tap_wr", 32'(bus.o_tap_wr), 0);
    chk("rst_tap", 32'(bus.o_tap), 0);
    chk("rst_ce", 32'(bus.o_ce), 0);
    chk("rst_sample", 32'(bus.o_sample), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_overrun", 32'(bus.o_overrun), 0);
    rst = 1'b0;
    @(negedge clk);

    // Passthrough vectors; the last one is a simultaneous load + sample into bank 2.
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("vec_ce", 32'(bus.o_ce), 32'(vecs[i-1].exp_ce));
        chk("vec_busy", 32'(bus.o_busy), 32'(vecs[i-1].exp_busy));
        chk("vec_overrun", 32'(bus.o_overrun), 0);
      end
      if (i < 6) begin
        bus.i_ce = vecs[i].ce; bus.i_load = vecs[i].load;
        bus.i_bank = vecs[i].bank; bus.i_sample = vecs[i].sample;
        if (vecs[i].exp_ce) sample_q.push_back(int'(vecs[i].sample));
        if (vecs[i].load) push_load(int'(vecs[i].bank));
      end else begin
        bus.i_ce = 1'b0; bus.i_load = 1'b0;
      end
    end
    chk("basic_addr0", 32'(bus.o_coef_addr), 32'(2 * N));
    // Basic reload with samples offered during LOAD to raise the sticky overrun.
    walk(DONE + 3, 0, 2, 0, 3, 5, -1, 0, -1, 0, 4);

    // Pending: bank 1 then bank 3 requested mid-load of bank 0; bank 3 must chain immediately.
    bus.i_load = 1'b1; bus.i_bank = 2'd0;
    push_load(0); push_load(3);
    @(negedge clk);
    bus.i_load = 1'b0;
    chk("pend_busy0", 32'(bus.o_busy), 1);
    chk("pend_ovr_clr", 32'(bus.o_overrun), 0);
    chk("pend_addr0", 32'(bus.o_coef_addr), 0);
    walk(2 * DONE + 2, DONE, 0, 3, -1, -1, 5, 1, 8, 3, -1);

    // Reset while tap 7 of bank 1 is on the write port, with a request pending.
    bus.i_load = 1'b1; bus.i_bank = 2'd1;
    push_load(1);
    @(negedge clk);
    bus.i_load = 1'b0;
    walk(9, 0, 1, 0, -1, -1, 4, 2, -1, 0, -1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(bus.o_coef_addr), 0);
    chk("mid_rst_tap_wr", 32'(bus.o_tap_wr), 0);
    chk("mid_rst_tap", 32'(bus.o_tap), 0);
    chk("mid_rst_ce", 32'(bus.o_ce), 0);
    chk("mid_rst_busy", 32'(bus.o_busy), 0);
    chk("mid_rst_overrun", 32'(bus.o_overrun), 0);
    tap_q.delete();
    sample_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(bus.o_busy), 0);
      chk("post_rst_tap_wr", 32'(bus.o_tap_wr), 0);
    end
    bus.i_load = 1'b1; bus.i_bank = 2'd1;
    push_load(1);
    @(negedge clk);
    bus.i_load = 1'b0;
    chk("restart_addr0", 32'(bus.o_coef_addr), 32'(N));
    chk("restart_busy", 32'(bus.o_busy), 1);
    walk(DONE + 2, 0, 1, 0, -1, -1, -1, 0, -1, 0, -1);

    chk("taps_left", 32'(tap_q.size()), 0);
    chk("samples_left", 32'(sample_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
